// File: rtl/shift_sched_32_pkg.sv
// Shared constants for the two-requester shift/rotate scheduler.
// Contents: operation encodings, FSM state encodings, data/amount widths.
// Everything here is pure declarations; no logic or timing.
package shift_sched_32_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Operation encodings carried on reqN_op; 101..111 are reserved.
    typedef enum logic [2:0] {
        OP_ROR  = 3'b000,
        OP_ROL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHRA = 3'b100
    } op_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sched_32_if.sv
// Request/response bundle between two requesters, one consumer and the scheduler.
// Ports: req0_*/req1_* valid-ready operation channels, rsp_* result channel.
// master = requester/consumer side, slave = scheduler side.
interface shift_sched_32_if;
    import shift_sched_32_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [2:0]          req0_op;
    logic [DATA_W-1:0]   req0_a;
    logic [AMT_W-1:0]    req0_amt;

    logic                req1_valid;
    logic                req1_ready;
    logic [2:0]          req1_op;
    logic [DATA_W-1:0]   req1_a;
    logic [AMT_W-1:0]    req1_amt;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_z;
    logic                rsp_id;
    logic                rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_amt,
        output req1_valid, req1_op, req1_a, req1_amt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_z, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_amt,
        input  req1_valid, req1_op, req1_a, req1_amt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_z, rsp_id, rsp_err
    );

endinterface

// File: rtl/rot_mask_32.sv
// Purpose: 32-bit rotate-right core plus per-op masking (ROR/ROL/SHR/SHL/SHRA).
// Latency: purely combinational. Backpressure: none.
// Ports: a operand, op encoding, amt amount -> z result, err (reserved op, z=0).
module rot_mask_32
    import shift_sched_32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [2:0]        op,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] z,
    output logic              err
);

    logic              left;
    logic [AMT_W-1:0]  r;
    logic [DATA_W-1:0] z_rot;
    logic [DATA_W-1:0] keep_hi;
    logic [DATA_W-1:0] keep_lo;

    always_comb begin
        // Left operations reuse the right rotator with amount (32 - amt) mod 32,
        // which in 5 bits is simply the two's complement of amt.
        left    = (op == OP_ROL) || (op == OP_SHL);
        r       = left ? (5'd0 - amt) : amt;
        // r == 0 makes the left term shift by 32, which yields 0 and leaves z_rot = a.
        z_rot   = (a >> r) | (a << (6'd32 - {1'b0, r}));
        keep_hi = 32'hFFFF_FFFF >> amt;   // bits that survive a right shift
        keep_lo = 32'hFFFF_FFFF << amt;   // bits that survive a left shift
        z       = z_rot;
        err     = 1'b0;
        case (op)
            OP_ROR, OP_ROL: z = z_rot;
            OP_SHR:         z = z_rot & keep_hi;
            OP_SHL:         z = z_rot & keep_lo;
            OP_SHRA:        z = (z_rot & keep_hi) | (a[31] ? ~keep_hi : 32'd0);
            default: begin
                z   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_sched_32.sv
// Purpose: shares one rotate/mask datapath between two requesters, round-robin, one op in flight.
// Latency: accept cycle -> EXEC -> RESP; rsp_valid is high two cycles after the accept cycle.
// Backpressure: result held stable until rsp_ready; no request accepted outside IDLE (1 op / 3 cycles).
// Ports: clk, reset_n (async, active-low), bus (slave modport of shift_sched_32_if).
module shift_sched_32
    import shift_sched_32_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    shift_sched_32_if.slave  bus
);

    state_t            state;
    logic              last_gnt;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [AMT_W-1:0]  amt_q;
    logic              id_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_z_q;
    logic              rsp_id_q;
    logic              rsp_err_q;

    logic              gnt_id;
    logic              idle_ok;
    logic              rdy0;
    logic              rdy1;
    logic              xfer;
    logic [DATA_W-1:0] dp_z;
    logic              dp_err;

    // On a tie the requester not granted last wins; otherwise the lone valid one.
    assign gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;
    // reset_n gates ready so it is low for the whole time reset is held.
    assign idle_ok = (state == ST_IDLE) && reset_n;
    assign rdy0    = idle_ok && bus.req0_valid && !gnt_id;
    assign rdy1    = idle_ok && bus.req1_valid &&  gnt_id;
    assign xfer    = rdy0 || rdy1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;

    rot_mask_32 u_rot_mask (
        .a   (a_q),
        .op  (op_q),
        .amt (amt_q),
        .z   (dp_z),
        .err (dp_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_gnt    <= 1'b1;   // requester 0 wins the first tie
            op_q        <= '0;
            a_q         <= '0;
            amt_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        op_q     <= gnt_id ? bus.req1_op  : bus.req0_op;
                        a_q      <= gnt_id ? bus.req1_a   : bus.req0_a;
                        amt_q    <= gnt_id ? bus.req1_amt : bus.req0_amt;
                        id_q     <= gnt_id;
                        last_gnt <= gnt_id;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_z_q     <= dp_z;
                    rsp_err_q   <= dp_err;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
